// File: rtl/slv_pkg.sv
// Shared types for the AXI write transaction guard (slv-flavoured bus).
// Contents:
//   - the default dimensions of the guard (MaxUniqIds, MaxTxnsPerId, CntWidth);
//   - cnt_t / txn_cnt_t counter types;
//   - the per-ID slot state enum;
//   - the slv AXI request/response structs.
// IDs on this bus are already remapped to AxiIntIdWidth bits.
package slv_pkg;

  localparam int unsigned MaxUniqIds    = 4;
  localparam int unsigned MaxTxnsPerId  = 12;
  localparam int unsigned CntWidth      = 10;
  localparam int unsigned AxiIntIdWidth = $clog2(MaxUniqIds);
  localparam int unsigned AxiAddrWidth  = 32;
  localparam int unsigned AxiDataWidth  = 32;

  typedef logic [CntWidth-1:0]                cnt_t;
  typedef logic [$clog2(MaxTxnsPerId+1)-1:0]  txn_cnt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    TIMEOUT = 2'd2
  } slot_state_e;

  typedef logic [AxiIntIdWidth-1:0] id_t;
  typedef logic [AxiAddrWidth-1:0]  addr_t;
  typedef logic [AxiDataWidth-1:0]  data_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } aw_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_chan_t;

  typedef struct packed {
    data_t                   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } slv_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } slv_resp_t;

endpackage

// File: rtl/axi_wr_guard_id_slot.sv
// Per-ID bookkeeping for the write transaction guard.
// Holds these per-ID items:
//   - the outstanding-write count;
//   - the head-of-line latency timer;
//   - the IDLE/BUSY/TIMEOUT state;
//   - the sticky timeout and unexpected-B flags.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   aw_fire_i, b_fire_i AW / B handshake completed for this ID this cycle
//   clr_i               clears the sticky flags (and the max latency)
//   budget_i            latency budget in cycles, 0 disables timeouts
//   cnt_o               outstanding write count
//   timeout_o           sticky timeout flag
//   unexp_b_o           sticky flag: B seen while count was 0
//   maxlat_o            running max of timer at B (only with AXI_WR_GUARD_MAXLAT_EN)
module axi_wr_guard_id_slot
  import slv_pkg::*;
#(
  parameter  int unsigned MaxTxnsPerId = slv_pkg::MaxTxnsPerId,
  parameter  int unsigned CntWidth     = slv_pkg::CntWidth,
  localparam int unsigned TxnW         = $clog2(MaxTxnsPerId+1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                aw_fire_i,
  input  logic                b_fire_i,
  input  logic                clr_i,
  input  logic [CntWidth-1:0] budget_i,
  output logic [TxnW-1:0]     cnt_o,
  output logic                timeout_o,
  output logic                unexp_b_o
`ifdef AXI_WR_GUARD_MAXLAT_EN
  ,
  output logic [CntWidth-1:0] maxlat_o
`endif
);

  localparam logic [CntWidth-1:0] TimerMax = '1;

  slot_state_e         state_q, state_d;
  logic [TxnW-1:0]     cnt_q, cnt_d;
  logic [CntWidth-1:0] timer_q, timer_d;
  logic                timeout_q, timeout_d;
  logic                unexp_q, unexp_d;
  logic                set_timeout, set_unexp;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (v == TimerMax) ? v : v + CntWidth'(1);
  endfunction

  always_comb begin
    cnt_d     = cnt_q;
    set_unexp = b_fire_i && (cnt_q == '0);
    if (aw_fire_i && !b_fire_i) begin
      cnt_d = cnt_q + TxnW'(1);
    end else if (b_fire_i && !aw_fire_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TxnW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    set_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_fire_i && (cnt_d != '0)) state_d = BUSY;
      end
      BUSY: begin
        if (cnt_d == '0) begin
          state_d = IDLE;
        end else if ((budget_i != '0) && (timer_q >= budget_i)) begin
          state_d     = TIMEOUT;
          set_timeout = 1'b1;
        end
      end
      TIMEOUT: begin
        // No retrigger from here: only a clear returns to BUSY.
        if (cnt_d == '0) state_d = IDLE;
        else if (clr_i)  state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase

    // Timer tracks the age of the oldest write; any B retires the head.
    if ((state_d == IDLE) || (state_q == IDLE) || b_fire_i) timer_d = '0;
    else                                                    timer_d = sat_inc(timer_q);

    // Setting beats a simultaneous clear.
    timeout_d = set_timeout | (timeout_q & ~clr_i);
    unexp_d   = set_unexp   | (unexp_q   & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      unexp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      unexp_q   <= unexp_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign timeout_o = timeout_q;
  assign unexp_b_o = unexp_q;

`ifdef AXI_WR_GUARD_MAXLAT_EN
  logic [CntWidth-1:0] maxlat_q, maxlat_d;

  // A B in the same cycle as a clear still gets recorded.
  always_comb begin
    maxlat_d = clr_i ? '0 : maxlat_q;
    if (b_fire_i && (timer_q > maxlat_d)) maxlat_d = timer_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) maxlat_q <= '0;
    else         maxlat_q <= maxlat_d;
  end

  assign maxlat_o = maxlat_q;
`endif

endmodule

// File: rtl/axi_wr_txn_guard.sv
// In-line AXI write transaction guard, upstream of the monitor core.
// Function:
//   - counts outstanding writes per internal ID;
//   - stalls AW for an ID that already has MaxTxnsPerId writes in flight;
//   - flags per ID a write that outlives budget_i cycles, and a B with no
//     matching outstanding write.
// AR/R/W/B pass through combinationally.
// Optional feature: define AXI_WR_GUARD_MAXLAT_EN to add maxlat_o.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   slv_req_i / slv_rsp_o    upstream side (from the ID remapper)
//   mst_req_o / mst_rsp_i    downstream side (monitor core / subordinate)
//   budget_i                 per-write cycle budget, 0 disables timeouts
//   clr_i                    per-ID pulse clearing sticky flags
//   outstanding_o            packed per-ID outstanding counts
//   timeout_o, unexp_b_o     sticky per-ID flags
//   irq_o                    registered OR of all flags
//   maxlat_o                 packed per-ID max latency (AXI_WR_GUARD_MAXLAT_EN only)
module axi_wr_txn_guard
  import slv_pkg::*;
#(
  parameter  int unsigned MaxUniqIds   = slv_pkg::MaxUniqIds,
  parameter  int unsigned MaxTxnsPerId = slv_pkg::MaxTxnsPerId,
  parameter  int unsigned CntWidth     = slv_pkg::CntWidth,
  parameter  type         req_t        = slv_req_t,
  parameter  type         rsp_t        = slv_resp_t,
  localparam int unsigned TxnW         = $clog2(MaxTxnsPerId+1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  req_t                         slv_req_i,
  output rsp_t                         slv_rsp_o,
  output req_t                         mst_req_o,
  input  rsp_t                         mst_rsp_i,
  input  logic [CntWidth-1:0]          budget_i,
  input  logic [MaxUniqIds-1:0]        clr_i,
  output logic [MaxUniqIds*TxnW-1:0]   outstanding_o,
  output logic [MaxUniqIds-1:0]        timeout_o,
  output logic [MaxUniqIds-1:0]        unexp_b_o,
  output logic                         irq_o
`ifdef AXI_WR_GUARD_MAXLAT_EN
  ,
  output logic [MaxUniqIds*CntWidth-1:0] maxlat_o
`endif
);

  logic [TxnW-1:0]       cnt [MaxUniqIds];
  logic                  aw_gated;
  logic [MaxUniqIds-1:0] aw_fire;
  logic [MaxUniqIds-1:0] b_fire;

  // Gate uses only the registered count, so aw_ready never depends on aw_valid.
  always_comb begin
    aw_gated = 1'b0;
    for (int unsigned i = 0; i < MaxUniqIds; i++) begin
      if ((32'(slv_req_i.aw.id) == i) && (cnt[i] == TxnW'(MaxTxnsPerId))) aw_gated = 1'b1;
    end
  end

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~aw_gated;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & ~aw_gated;
  end

  always_comb begin
    aw_fire = '0;
    b_fire  = '0;
    for (int unsigned i = 0; i < MaxUniqIds; i++) begin
      aw_fire[i] = mst_req_o.aw_valid & mst_rsp_i.aw_ready & (32'(slv_req_i.aw.id) == i);
      b_fire[i]  = mst_rsp_i.b_valid & slv_req_i.b_ready & (32'(mst_rsp_i.b.id) == i);
    end
  end

  for (genvar g = 0; g < MaxUniqIds; g++) begin : gen_slot
    axi_wr_guard_id_slot #(
      .MaxTxnsPerId (MaxTxnsPerId),
      .CntWidth     (CntWidth)
    ) i_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .aw_fire_i (aw_fire[g]),
      .b_fire_i  (b_fire[g]),
      .clr_i     (clr_i[g]),
      .budget_i  (budget_i),
      .cnt_o     (cnt[g]),
      .timeout_o (timeout_o[g]),
      .unexp_b_o (unexp_b_o[g])
`ifdef AXI_WR_GUARD_MAXLAT_EN
      ,
      .maxlat_o  (maxlat_o[g*CntWidth +: CntWidth])
`endif
    );

    assign outstanding_o[g*TxnW +: TxnW] = cnt[g];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_o <= 1'b0;
    else         irq_o <= |{timeout_o, unexp_b_o};
  end

endmodule

// File: tb/tb_axi_wr_txn_guard.sv
// Bench for axi_wr_txn_guard.
// Structure:
//   - directed scenarios plus a randomized phase;
//   - every cycle is compared against a behavioural model that tracks the
//     outstanding count and the head-write age per ID.
module tb_axi_wr_txn_guard;
  import slv_pkg::*;

  localparam int NId  = MaxUniqIds;
  localparam int NMax = MaxTxnsPerId;
  localparam int TW   = $clog2(NMax+1);
  localparam int CMAX = (1 << CntWidth) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_ni;
  slv_req_t                slv_req, mst_req;
  slv_resp_t               slv_rsp, mst_rsp;
  logic [CntWidth-1:0]     budget;
  logic [NId-1:0]          clr;
  logic [NId*TW-1:0]       outstanding;
  logic [NId-1:0]          timeout, unexp_b;
  logic                    irq;
`ifdef AXI_WR_GUARD_MAXLAT_EN
  logic [NId*CntWidth-1:0] maxlat;
`endif

  axi_wr_txn_guard #(
    .MaxUniqIds   (NId),
    .MaxTxnsPerId (NMax),
    .CntWidth     (CntWidth),
    .req_t        (slv_req_t),
    .rsp_t        (slv_resp_t)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .slv_req_i     (slv_req),
    .slv_rsp_o     (slv_rsp),
    .mst_req_o     (mst_req),
    .mst_rsp_i     (mst_rsp),
    .budget_i      (budget),
    .clr_i         (clr),
    .outstanding_o (outstanding),
    .timeout_o     (timeout),
    .unexp_b_o     (unexp_b),
    .irq_o         (irq)
`ifdef AXI_WR_GUARD_MAXLAT_EN
    ,
    .maxlat_o      (maxlat)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: count, whether a write is pending, the edge at which the
  // head write started aging, whether the ID is latched in timeout, flags.
  int cyc = 0;
  int m_cnt[NId];
  bit m_act[NId];
  bit m_tmo[NId];
  int m_start[NId];
  bit m_tflag[NId];
  bit m_uflag[NId];
  int m_maxlat[NId];
  bit m_irq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NId; i++) begin
      m_cnt[i] = 0; m_act[i] = 0; m_tmo[i] = 0; m_start[i] = 0;
      m_tflag[i] = 0; m_uflag[i] = 0; m_maxlat[i] = 0;
    end
    m_irq = 0;
  endtask

  function automatic int m_age(input int i);
    int a;
    if (!m_act[i]) return 0;
    a = cyc - m_start[i];
    return (a > CMAX) ? CMAX : a;
  endfunction

  function automatic bit m_gated();
    return m_cnt[int'(slv_req.aw.id)] == NMax;
  endfunction

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit nirq;
    nirq = 0;
    for (int i = 0; i < NId; i++) nirq |= m_tflag[i] | m_uflag[i];
    for (int i = 0; i < NId; i++) begin
      bit aw, b, tset, uset;
      int t, nc;
      aw = slv_req.aw_valid && mst_rsp.aw_ready && !m_gated() && (int'(slv_req.aw.id) == i);
      b  = mst_rsp.b_valid && slv_req.b_ready && (int'(mst_rsp.b.id) == i);
      t  = m_age(i);
      nc = m_cnt[i] + int'(aw && !b) - int'(b && !aw && m_cnt[i] > 0);
      tset = 0;
      uset = b && (m_cnt[i] == 0);
      if (nc == 0) begin
        m_act[i] = 0; m_tmo[i] = 0;
      end else if (!m_act[i]) begin
        m_act[i] = 1; m_start[i] = cyc + 1;
      end else begin
        if (m_tmo[i]) begin
          if (clr[i]) m_tmo[i] = 0;
        end else if (budget != 0 && t >= int'(budget)) begin
          m_tmo[i] = 1; tset = 1;
        end
        if (b) m_start[i] = cyc + 1;
      end
      if (clr[i]) m_maxlat[i] = 0;
      if (b && t > m_maxlat[i]) m_maxlat[i] = t;
      m_tflag[i] = tset | (m_tflag[i] & !clr[i]);
      m_uflag[i] = uset | (m_uflag[i] & !clr[i]);
      m_cnt[i]   = nc;
    end
    m_irq = nirq;
    cyc++;
  endtask

  task automatic check_comb();
    bit g;
    g = m_gated();
    check("aw_valid_gate", mst_req.aw_valid, slv_req.aw_valid && !g);
    check("aw_ready_gate", slv_rsp.aw_ready, mst_rsp.aw_ready && !g);
    check("aw_payload", mst_req.aw, slv_req.aw);
    check("w_pass", {mst_req.w_valid, mst_req.w}, {slv_req.w_valid, slv_req.w});
    check("ar_pass", {mst_req.ar_valid, mst_req.ar}, {slv_req.ar_valid, slv_req.ar});
    check("b_pass", {slv_rsp.b_valid, slv_rsp.b}, {mst_rsp.b_valid, mst_rsp.b});
    check("r_pass", {slv_rsp.r_valid, slv_rsp.r}, {mst_rsp.r_valid, mst_rsp.r});
    check("readies", {mst_req.b_ready, mst_req.r_ready, slv_rsp.w_ready, slv_rsp.ar_ready},
          {slv_req.b_ready, slv_req.r_ready, mst_rsp.w_ready, mst_rsp.ar_ready});
  endtask

  task automatic check_regs();
    logic [NId-1:0] et, eu;
    for (int i = 0; i < NId; i++) begin
      et[i] = m_tflag[i];
      eu[i] = m_uflag[i];
      check($sformatf("outstanding[%0d]", i), outstanding[i*TW +: TW], m_cnt[i]);
`ifdef AXI_WR_GUARD_MAXLAT_EN
      check($sformatf("maxlat[%0d]", i), maxlat[i*CntWidth +: CntWidth], m_maxlat[i]);
`endif
    end
    check("timeout", timeout, et);
    check("unexp_b", unexp_b, eu);
    check("irq", irq, m_irq);
  endtask

  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    slv_req = '0;
    mst_rsp = '0;
    slv_req.b_ready  = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    clr = '0;
  endtask

  task automatic randomize_payloads();
    logic [63:0] rnd;
    rnd = {$urandom, $urandom}; slv_req.aw = rnd[$bits(aw_chan_t)-1:0];
    rnd = {$urandom, $urandom}; slv_req.ar = rnd[$bits(ar_chan_t)-1:0];
    rnd = {$urandom, $urandom}; slv_req.w  = rnd[$bits(w_chan_t)-1:0];
    rnd = {$urandom, $urandom}; mst_rsp.r  = rnd[$bits(r_chan_t)-1:0];
    rnd = {$urandom, $urandom}; mst_rsp.b  = rnd[$bits(b_chan_t)-1:0];
    rnd = {$urandom, $urandom};
    {slv_req.w_valid, slv_req.ar_valid, slv_req.r_ready,
     mst_rsp.ar_ready, mst_rsp.w_ready, mst_rsp.r_valid} = rnd[5:0];
  endtask

  initial begin
    int k;
    idle_inputs();
    budget = '0;
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    check("rst_outstanding", outstanding, 0);
    check("rst_irq", irq, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Fill ID 1 to the limit with B held off.
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 2'd1;
    repeat (NMax) begin
      slv_req.aw.addr = $urandom;
      step();
    end
    check("fill_out12", outstanding[1*TW +: TW], 12);
    #1;
    check("fill_13th_ready", slv_rsp.aw_ready, 0);
    check("fill_13th_valid", mst_req.aw_valid, 0);
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 2'd1;
    step();
    mst_rsp.b_valid = 1'b0;
    #1;
    check("fill_13th_ready_after_b", slv_rsp.aw_ready, 1);
    step();
    check("fill_13th_accepted", outstanding[1*TW +: TW], 12);
    slv_req.aw_valid = 1'b0;
    mst_rsp.b_valid  = 1'b1;
    repeat (NMax) step();
    mst_rsp.b_valid  = 1'b0;
    check("drain_out0", outstanding[1*TW +: TW], 0);

    // Timeout after budget 20 on ID 2.
    budget = CntWidth'(20);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 2'd2;
    step();
    slv_req.aw_valid = 1'b0;
    repeat (20) step();
    check("tmo_not_yet", timeout[2], 0);
    step();
    check("tmo_at_21", timeout[2], 1);
    check("irq_lags", irq, 0);
    step();
    check("irq_set", irq, 1);
    clr[2] = 1'b1;
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 2'd2;
    step();
    clr = '0;
    mst_rsp.b_valid = 1'b0;
    check("tmo_cleared", timeout[2], 0);
    step();
    check("irq_cleared", irq, 0);

    // Budget 0: no timeout, timer saturates.
    budget = '0;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 2'd3;
    step();
    slv_req.aw_valid = 1'b0;
    repeat (1100) step();
    check("no_tmo_budget0", timeout[3], 0);
    budget = CntWidth'(CMAX);
    step();
    check("timer_saturated", timeout[3], 1);
    clr[3] = 1'b1;
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 2'd3;
    step();
    clr = '0;
    mst_rsp.b_valid = 1'b0;
    budget = '0;
    step();

    // Unsolicited B on ID 0.
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 2'd0;
    step();
    mst_rsp.b_valid = 1'b0;
    check("unexp_set", unexp_b[0], 1);
    check("unexp_cnt0", outstanding[0*TW +: TW], 0);
    step();
    check("unexp_irq", irq, 1);
    clr[0] = 1'b1;
    step();
    clr = '0;
    step();

    // Simultaneous AW and B on ID 1 with 3 outstanding.
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 2'd1;
    repeat (3) step();
    slv_req.aw_valid = 1'b0;
    repeat (30) step();
    slv_req.aw_valid = 1'b1;
    mst_rsp.b_valid  = 1'b1;
    mst_rsp.b.id     = 2'd1;
    step();
    slv_req.aw_valid = 1'b0;
    mst_rsp.b_valid  = 1'b0;
    check("both_cnt3", outstanding[1*TW +: TW], 3);
    budget = CntWidth'(5);
    step();
    check("both_timer_reset", timeout[1], 0);
    repeat (4) step();
    check("both_tmo_early", timeout[1], 0);
    step();
    check("both_tmo_6", timeout[1], 1);
    clr[1] = 1'b1;
    mst_rsp.b_valid = 1'b1;
    step();
    clr = '0;
    repeat (2) step();
    mst_rsp.b_valid = 1'b0;
    budget = '0;
    step();

    // Randomized traffic.
    repeat (400) begin
      randomize_payloads();
      slv_req.aw_valid = ($urandom_range(0, 2) == 0);
      slv_req.aw.id    = 2'($urandom_range(0, NId-1));
      mst_rsp.aw_ready = ($urandom_range(0, 3) != 0);
      slv_req.b_ready  = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, NId-1);
      mst_rsp.b.id    = 2'(k);
      mst_rsp.b_valid = 1'b0;
      if (m_cnt[k] > 0 && $urandom_range(0, 2) == 0) mst_rsp.b_valid = 1'b1;
      else if (!slv_req.aw_valid && $urandom_range(0, 15) == 0) mst_rsp.b_valid = 1'b1;
      clr = ($urandom_range(0, 7) == 0) ? NId'($urandom) : '0;
      if ($urandom_range(0, 31) == 0)
        budget = ($urandom_range(0, 1) == 0) ? '0 : CntWidth'($urandom_range(3, 40));
      step();
    end

    // Reset with writes in flight.
    idle_inputs();
    step();
    slv_req.aw_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      slv_req.aw.id = 2'(j % NId);
      step();
    end
    slv_req.aw_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("midrst_outstanding", outstanding, 0);
    check("midrst_flags", {timeout, unexp_b}, 0);
    check("midrst_irq", irq, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 2'd2;
    step();
    mst_rsp.b_valid = 1'b0;
    check("midrst_late_b_unexp", unexp_b[2], 1);
    check("midrst_late_b_cnt", outstanding[2*TW +: TW], 0);
    step();
    check("midrst_late_b_irq", irq, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
